// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared defaults, state encoding, row type and the per-cell
//                Game-of-Life rule for the generation stepper.
//  Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

  localparam int C_WIDTH  = 11;
  localparam int C_HEIGHT = 11;
  localparam int C_GEN_W  = 16;

  typedef logic [C_WIDTH-1:0] row_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD0 = 3'd1,
    ST_LOAD1 = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Neighbour bits in, next cell state out. The count is 4 bits so the
  // fully-surrounded case (8) cannot overflow.
  function automatic logic cell_next(input logic [7:0] nbr, input logic alive);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'b000, nbr[k]};
    end
    return (n == 4'd3) | (alive & (n == 4'd2));
  endfunction

endpackage
`default_nettype wire

// File: rtl/life_row_rule.sv
`default_nettype none
// ============================================================================
//  Module      : life_row_rule
//  Description : Combinational next-generation row from the three-row window
//                (above, cur, below). Cells beyond either edge read as dead.
//  Revision    : 1.0 - initial release
// ============================================================================
module life_row_rule
  import life_pkg::*;
#(
  parameter int WIDTH = C_WIDTH
) (
  input  logic [WIDTH-1:0] i_above,
  input  logic [WIDTH-1:0] i_cur,
  input  logic [WIDTH-1:0] i_below,
  output logic [WIDTH-1:0] o_next
);

  // One dead column padded on each side so every cell sees a 3-wide slice.
  logic [WIDTH+1:0] w_above_p;
  logic [WIDTH+1:0] w_cur_p;
  logic [WIDTH+1:0] w_below_p;

  assign w_above_p = {1'b0, i_above, 1'b0};
  assign w_cur_p   = {1'b0, i_cur,   1'b0};
  assign w_below_p = {1'b0, i_below, 1'b0};

  genvar c;
  generate
    for (c = 0; c < WIDTH; c++) begin : g_cell
      logic [7:0] w_nbr;
      // Padded index c+1 is board column c; the centre cell itself is excluded.
      assign w_nbr     = {w_above_p[c+2:c], w_below_p[c+2:c], w_cur_p[c+2], w_cur_p[c]};
      assign o_next[c] = cell_next(w_nbr, i_cur[c]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/life_gen_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : life_gen_stepper
//  Description : Steps a HEIGHT x WIDTH Game-of-Life board held in an external
//                row-register bank by one generation, one row per cycle,
//                using a three-row sliding window so the update is in place.
//  Revision    : 1.0 - initial release
// ============================================================================
module life_gen_stepper
  import life_pkg::*;
#(
  parameter int WIDTH  = C_WIDTH,
  parameter int HEIGHT = C_HEIGHT,
  parameter int ROW_AW = $clog2(HEIGHT),
  parameter int GEN_W  = C_GEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ROW_AW-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [ROW_AW-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic [GEN_W-1:0]  gen_count
);

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_above;
  logic [WIDTH-1:0]  r_cur;
  logic [WIDTH-1:0]  r_below;
  logic [ROW_AW-1:0] r_row;
  logic [GEN_W-1:0]  r_gen_count;

  logic [ROW_AW:0]   w_row_p2;
  logic              w_have_below;
  logic              w_last_row;
  logic              w_step;
  logic [WIDTH-1:0]  w_next_row;
  logic [ROW_AW-1:0] w_rd_addr;

  // One extra bit so r+2 cannot wrap when HEIGHT fills the address space.
  assign w_row_p2     = {1'b0, r_row} + (ROW_AW+1)'(2);
  assign w_have_below = (w_row_p2 < (ROW_AW+1)'(HEIGHT));
  assign w_last_row   = (r_row == ROW_AW'(HEIGHT-1));

  life_row_rule #(
    .WIDTH (WIDTH)
  ) u_row_rule (
    .i_above (r_above),
    .i_cur   (r_cur),
    .i_below (r_below),
    .o_next  (w_next_row)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and read-address decode.
  always_comb begin
    w_state_next = r_state;
    w_rd_addr    = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_LOAD0;
      end
      ST_LOAD0: begin
        w_rd_addr    = '0;
        w_state_next = ST_LOAD1;
      end
      ST_LOAD1: begin
        w_rd_addr    = ROW_AW'(1);
        w_state_next = ST_STEP;
      end
      ST_STEP: begin
        w_rd_addr = w_have_below ? w_row_p2[ROW_AW-1:0] : '0;
        if (w_last_row) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Writes are suppressed combinationally while reset is held so an aborted
  // run never lands another row in the bank.
  assign w_step    = (r_state == ST_STEP) && reset;
  assign we        = w_step;
  assign wr_addr   = w_step ? r_row : '0;
  assign wr_data   = w_step ? w_next_row : '0;
  assign rd_addr   = w_rd_addr;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign gen_count = r_gen_count;

  // Window buffers, row index and generation counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_above     <= '0;
      r_cur       <= '0;
      r_below     <= '0;
      r_row       <= '0;
      r_gen_count <= '0;
    end else begin
      unique case (r_state)
        ST_LOAD0: begin
          r_cur   <= rd_data;
          r_above <= '0;
        end
        ST_LOAD1: begin
          r_below <= rd_data;
          r_row   <= '0;
        end
        ST_STEP: begin
          // The original row r slides into above, so overwriting it in the
          // bank this cycle does not disturb the next step.
          r_above <= r_cur;
          r_cur   <= r_below;
          r_below <= w_have_below ? rd_data : '0;
          if (!w_last_row) r_row <= r_row + ROW_AW'(1);
        end
        ST_DONE: begin
          r_gen_count <= r_gen_count + GEN_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_life_gen_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_gen_stepper
//  Description : Bench for life_gen_stepper with an 11 x 11 row-register bank.
//                Expected writes and done pulses go into queues; a monitor on
//                the falling edge pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_life_gen_stepper;
  import life_pkg::*;

  localparam int W = 11;
  localparam int H = 11;
  localparam int AW = 4;

  typedef row_t board_t [H];

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_exp_t;

  typedef struct {
    int gen_before;
    int cyc;
  } done_exp_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          we;
  logic          busy;
  logic          done;
  logic [15:0]   gen_count;

  board_t    bank;
  board_t    pl_board;
  logic      pl_en;
  int        cyc;
  int        checks;
  int        errors;
  wr_exp_t   exp_wr[$];
  done_exp_t exp_done[$];

  life_gen_stepper #(
    .WIDTH  (W),
    .HEIGHT (H),
    .ROW_AW (AW),
    .GEN_W  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .we        (we),
    .busy      (busy),
    .done      (done),
    .gen_count (gen_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Row register bank: per-row write enable decoded from wr_addr.
  always @(posedge clk) begin
    if (pl_en) bank <= pl_board;
    else if (we && (wr_addr < AW'(H))) bank[wr_addr] <= wr_data;
  end

  assign rd_data = (rd_addr < AW'(H)) ? bank[rd_addr] : '0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every write and every done pulse must match the queue head.
  always @(negedge clk) begin
    if (we) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h at cycle %0d, expected none",
                 wr_addr, wr_data, cyc);
      end else begin
        wr_exp_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", int'(wr_addr), e.addr);
        chk("wr_data", int'(wr_data), e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: at cycle %0d, expected none", cyc);
      end else begin
        done_exp_t d;
        d = exp_done.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("gen_in_done", int'(gen_count), d.gen_before);
      end
    end
  end

  task automatic preload(input board_t b);
    pl_board = b;
    pl_en    = 1'b1;
    @(posedge clk); #1;
    pl_en    = 1'b0;
  endtask

  task automatic check_board(input string nm, input board_t exp);
    for (int i = 0; i < H; i++) begin
      chk($sformatf("%s_row%0d", nm, i), int'(bank[i]), int'(exp[i]));
    end
  endtask

  // One full generation: fixed latency, so the loop itself bounds the run.
  task automatic run_gen(input string nm, input board_t init, input board_t exp,
                         input int gen, input int extra_start, input bit chk_busy);
    int t0;
    preload(init);
    start = 1'b1;
    t0    = cyc;
    for (int i = 0; i < H; i++) begin
      exp_wr.push_back('{addr: i, data: int'(exp[i]), cyc: t0 + 3 + i});
    end
    exp_done.push_back('{gen_before: gen - 1, cyc: t0 + H + 3});
    for (int k = 1; k <= H + 10; k++) begin
      @(posedge clk); #1;
      start = (k == extra_start);
      if (chk_busy && k <= H + 5) begin
        @(negedge clk);
        chk($sformatf("%s_busy_c%0d", nm, k), int'(busy), (k <= H + 3) ? 1 : 0);
      end
    end
    chk($sformatf("%s_pending_writes", nm), exp_wr.size(), 0);
    chk($sformatf("%s_pending_done", nm), exp_done.size(), 0);
    exp_wr.delete();
    exp_done.delete();
    chk($sformatf("%s_gen_count", nm), int'(gen_count), gen);
    check_board(nm, exp);
  endtask

  board_t b_zero, b_hblink, b_vblink, b_block, b_single;
  board_t b_top, b_top_n, b_bot, b_bot_n, b_rst, b_rst_n;

  initial begin
    int t0;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    start  = 1'b0;
    pl_en  = 1'b0;
    b_zero = '{default: '0};
    pl_board = b_zero;

    b_hblink = b_zero; b_hblink[5] = 11'b00000111000;
    b_vblink = b_zero;
    b_vblink[4] = 11'b00000010000;
    b_vblink[5] = 11'b00000010000;
    b_vblink[6] = 11'b00000010000;
    b_block  = b_zero; b_block[2] = 11'b00000001100; b_block[3] = 11'b00000001100;
    b_single = b_zero; b_single[7] = 11'b00010000000;
    b_top    = b_zero; b_top[0] = 11'h7FF;
    b_top_n  = b_zero; b_top_n[0] = 11'b01111111110; b_top_n[1] = 11'b01111111110;
    b_bot    = b_zero; b_bot[10] = 11'h7FF;
    b_bot_n  = b_zero; b_bot_n[10] = 11'b01111111110; b_bot_n[9] = 11'b01111111110;
    // Rows 0..4 full: only the two corner cells of row 0 survive; rows 1..3 die.
    b_rst    = b_zero;
    for (int i = 0; i < 5; i++) b_rst[i] = 11'h7FF;
    b_rst_n  = b_rst;
    b_rst_n[0] = 11'b10000000001;
    b_rst_n[1] = 11'b00000000000;
    b_rst_n[2] = 11'b00000000000;

    preload(b_zero);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", int'(we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_gen_count", int'(gen_count), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_gen("blink1", b_hblink, b_vblink, 1, -1, 1'b0);
    run_gen("blink2", b_vblink, b_hblink, 2, -1, 1'b0);
    run_gen("block",  b_block,  b_block,  3, -1, 1'b0);
    run_gen("single", b_single, b_zero,   4, -1, 1'b0);
    run_gen("top",    b_top,    b_top_n,  5, -1, 1'b0);
    run_gen("bottom", b_bot,    b_bot_n,  6, -1, 1'b0);
    run_gen("timing", b_hblink, b_vblink, 7,  5, 1'b1);

    // Reset in cycle 6 of a run: rows 0..2 written, nothing after.
    preload(b_rst);
    start = 1'b1;
    t0    = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_wr.push_back('{addr: i, data: int'(b_rst_n[i]), cyc: t0 + 3 + i});
    end
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 6) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we", int'(we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_gen_count", int'(gen_count), 0);
    chk("abort_pending_writes", exp_wr.size(), 0);
    exp_wr.delete();
    repeat (3) @(posedge clk);
    #1;
    check_board("abort", b_rst_n);

    run_gen("after_abort", b_hblink, b_vblink, 1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
